// File: rtl/multiword_add_sub_seq_pkg.sv
// Shared definitions for the multi-word sequential adder/subtractor:
// FSM state encodings, opcode constants and a clog2 helper.
package multiword_add_sub_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Ceiling log2, never less than 1 so a counter always has at least one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/multiword_add_sub_seq_add_sub_slice.sv
// add_sub_slice: combinational WORD_W-bit adder/subtractor slice.
// Ports:
//   a, b     - operand words
//   sub      - OP_SUB inverts b (the +1 comes in through cin)
//   cin      - carry in
//   sum_c    - result word
//   cout_c   - carry out of the slice MSB
//   cmsb_c   - carry into the slice MSB (for signed overflow detection)
module add_sub_slice
    import multiword_add_sub_seq_pkg::*;
#(
    parameter int unsigned WORD_W = 16
) (
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              sub,
    input  logic              cin,
    output logic [WORD_W-1:0] sum_c,
    output logic              cout_c,
    output logic              cmsb_c
);

    localparam int unsigned SW = WORD_W + 1;

    logic [WORD_W-1:0] b_eff;
    logic [WORD_W:0]   full;

    // One wide add; the carry into the MSB is recovered from the MSB sum bit.
    always_comb begin
        b_eff  = (sub == OP_SUB) ? ~b : b;
        full   = {1'b0, a} + {1'b0, b_eff} + SW'(cin);
        sum_c  = full[WORD_W-1:0];
        cout_c = full[WORD_W];
        cmsb_c = full[WORD_W-1] ^ a[WORD_W-1] ^ b_eff[WORD_W-1];
    end

endmodule

// File: rtl/multiword_add_sub_seq.sv
// multiword_add_sub_seq: WORD_W*NUM_WORDS-bit add/subtract computed one
// word per clock (LSW first) through a single add_sub_slice, with the carry
// chained between words in a register.
// Ports:
//   clk, rst_n          - clock, async active-low reset
//   in_valid/in_ready   - operation request handshake
//   in_a, in_b          - TW-bit operands
//   in_add_n            - 0 = A+B, 1 = A-B
//   out_valid/out_ready - result handshake
//   out_sum             - result modulo 2^TW
//   out_cout            - carry out of MSB (on subtract 1 = no borrow)
//   out_ovf             - signed two's-complement overflow
module multiword_add_sub_seq
    import multiword_add_sub_seq_pkg::*;
#(
    parameter int unsigned WORD_W    = 16,
    parameter int unsigned NUM_WORDS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WORD_W*NUM_WORDS-1:0]   in_a,
    input  logic [WORD_W*NUM_WORDS-1:0]   in_b,
    input  logic                          in_add_n,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WORD_W*NUM_WORDS-1:0]   out_sum,
    output logic                          out_cout,
    output logic                          out_ovf
);

    localparam int unsigned TW    = WORD_W * NUM_WORDS;
    localparam int unsigned IDX_W = clog2_min1(NUM_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_t             state_q;
    state_t             state_d;
    logic [TW-1:0]      a_q;
    logic [TW-1:0]      b_q;
    logic               add_n_q;
    logic               carry_q;
    logic [IDX_W-1:0]   idx_q;

    logic               accept_c;
    logic               step_c;
    logic               last_c;

    logic [WORD_W-1:0]  slice_sum;
    logic               slice_cout;
    logic               slice_cmsb;

    add_sub_slice #(
        .WORD_W (WORD_W)
    ) u_slice (
        .a      (a_q[WORD_W-1:0]),
        .b      (b_q[WORD_W-1:0]),
        .sub    (add_n_q),
        .cin    (carry_q),
        .sum_c  (slice_sum),
        .cout_c (slice_cout),
        .cmsb_c (slice_cmsb)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, handshake and datapath strobes
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        accept_c = 1'b0;
        step_c   = 1'b0;
        last_c   = (idx_q == LAST_IDX);
        unique case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept_c = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                step_c = 1'b1;
                if (last_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Popping the result frees the slot for a same-edge accept.
                in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        accept_c = 1'b1;
                        state_d  = ST_RUN;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Operand shifters, carry chain, word index and registered results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            add_n_q   <= 1'b0;
            carry_q   <= 1'b0;
            idx_q     <= '0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= (state_d == ST_DONE);
            if (accept_c) begin
                a_q     <= in_a;
                b_q     <= in_b;
                add_n_q <= in_add_n;
                // Subtract is A + ~B + 1: the +1 enters as the initial carry.
                carry_q <= (in_add_n == OP_SUB);
                idx_q   <= '0;
            end else if (step_c) begin
                a_q     <= a_q >> WORD_W;
                b_q     <= b_q >> WORD_W;
                carry_q <= slice_cout;
                idx_q   <= idx_q + IDX_W'(1);
                // New word enters at the top; after NUM_WORDS steps the LSW
                // has reached bit 0.
                out_sum <= TW'({slice_sum, out_sum} >> WORD_W);
                if (last_c) begin
                    out_cout <= slice_cout;
                    out_ovf  <= slice_cmsb ^ slice_cout;
                end
            end
        end
    end

endmodule

// File: tb/tb_multiword_add_sub_seq.sv
// Self-checking bench for multiword_add_sub_seq: a 64-bit (16x4) instance
// and a 16-bit (16x1) instance, checked against a plain-arithmetic model.
module tb_multiword_add_sub_seq;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid, in_ready, in_add_n, out_valid, out_ready, out_cout, out_ovf;
    logic [63:0] in_a, in_b, out_sum;

    logic        s_in_valid, s_in_ready, s_in_add_n, s_out_valid, s_out_ready, s_out_cout, s_out_ovf;
    logic [15:0] s_in_a, s_in_b, s_out_sum;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multiword_add_sub_seq #(.WORD_W(16), .NUM_WORDS(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_add_n(in_add_n),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
    );

    multiword_add_sub_seq #(.WORD_W(16), .NUM_WORDS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_a(s_in_a), .in_b(s_in_b), .in_add_n(s_in_add_n),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_sum(s_out_sum), .out_cout(s_out_cout), .out_ovf(s_out_ovf)
    );

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        sub;
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: n-bit unsigned arithmetic; borrow/overflow from operand signs.
    function automatic void model(input logic [63:0] a, input logic [63:0] b, input logic sub,
                                  input int n, output logic [63:0] s, output logic c,
                                  output logic o);
        logic [63:0] mask, am, bm;
        logic [64:0] full;
        logic        sa, sb, ss;
        mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
        am   = a & mask;
        bm   = b & mask;
        if (sub) begin
            s = (am - bm) & mask;
            c = (am >= bm);
        end else begin
            full = {1'b0, am} + {1'b0, bm};
            s    = full[63:0] & mask;
            c    = full[n];
        end
        sa = am[n-1];
        sb = bm[n-1];
        ss = s[n-1];
        o  = sub ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
    endfunction

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("pop_valid_low", 64'(out_valid), 64'd0);
    endtask

    // One full operation on the 64-bit instance, checked against the model.
    // junk: keep a bogus request on in_valid during RUN (must be ignored).
    task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic sub, input int stall, input logic junk);
        logic [63:0] es;
        logic        ec, eo;
        int          lat;
        model(a, b, sub, 64, es, ec, eo);
        @(negedge clk);
        in_a = a; in_b = b; in_add_n = sub; in_valid = 1'b1;
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = junk;
        in_a     = ~a;
        in_b     = a ^ b;
        in_add_n = ~sub;
        wait_valid(lat);
        chk({tag, "_latency"}, 64'(lat), 64'd4);
        chk({tag, "_sum"}, out_sum, es);
        chk({tag, "_cout"}, 64'(out_cout), 64'(ec));
        chk({tag, "_ovf"}, 64'(out_ovf), 64'(eo));
        in_valid = 1'b0;
        if (stall > 0) begin
            repeat (stall) @(negedge clk);
            chk({tag, "_stall_sum"}, out_sum, es);
            chk({tag, "_stall_valid"}, 64'(out_valid), 64'd1);
        end
        pop();
    endtask

    initial begin
        logic [63:0] es1, es2;
        logic        ec, eo;
        int          lat;

        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] es1, es2, ra, rb;
        logic        ec1, eo1, ec2, eo2, rs;
        int          lat;

        vecs[0] = '{64'h0000FFFFFFFFFFFF, 64'd1, 1'b0, 64'h0001000000000000, 1'b0, 1'b0};
        vecs[1] = '{64'd0, 64'd1, 1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0};
        vecs[2] = '{64'd5, 64'd3, 1'b1, 64'd2, 1'b1, 1'b0};
        vecs[3] = '{64'h7FFFFFFFFFFFFFFF, 64'd1, 1'b0, 64'h8000000000000000, 1'b0, 1'b1};
        vecs[4] = '{64'h8000000000000000, 64'd1, 1'b1, 64'h7FFFFFFFFFFFFFFF, 1'b1, 1'b1};

        rst_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_add_n = 1'b0; out_ready = 1'b0;
        s_in_valid = 1'b0; s_in_a = '0; s_in_b = '0; s_in_add_n = 1'b0; s_out_ready = 1'b0;

        // Reset state
        #3;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_sum", out_sum, 64'd0);
        chk("rst_out_cout", 64'(out_cout), 64'd0);
        chk("rst_out_ovf", 64'(out_ovf), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors with hand-computed expectations
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_a = vecs[i].a; in_b = vecs[i].b; in_add_n = vecs[i].sub; in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            wait_valid(lat);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
            chk($sformatf("vec%0d_sum", i), out_sum, vecs[i].sum);
            chk($sformatf("vec%0d_cout", i), 64'(out_cout), 64'(vecs[i].cout));
            chk($sformatf("vec%0d_ovf", i), 64'(out_ovf), 64'(vecs[i].ovf));
            pop();
        end

        // Backpressure with a pending request, then same-edge pop+accept
        model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 64, es1, ec1, eo1);
        model(64'h0000_0000_0001_0000, 64'h0000_0000_0000_0001, 1'b1, 64, es2, ec2, eo2);
        @(negedge clk);
        in_a = 64'h1234_5678_9ABC_DEF0; in_b = 64'h0FED_CBA9_8765_4321; in_add_n = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(lat);
        chk("bp_first_latency", 64'(lat), 64'd4);
        in_a = 64'h0000_0000_0001_0000; in_b = 64'd1; in_add_n = 1'b1; in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_out_sum", out_sum, es1);
            chk("bp_out_cout", 64'(out_cout), 64'(ec1));
        end
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_follows", 64'(in_ready), 64'd1);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("bp_popped_valid", 64'(out_valid), 64'd0);
        chk("bp_running_ready", 64'(in_ready), 64'd0);
        wait_valid(lat);
        chk("bp_second_latency", 64'(lat), 64'd4);
        chk("bp_second_sum", out_sum, es2);
        chk("bp_second_cout", 64'(out_cout), 64'(ec2));
        chk("bp_second_ovf", 64'(out_ovf), 64'(eo2));
        pop();

        // Randomized operations against the model
        for (int i = 0; i < 40; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: rb = ra;
                1: ra = {1'b0, {63{1'b1}}};
                2: rb = {1'b1, 63'd0};
                default: ;
            endcase
            rs = 1'($urandom_range(0, 1));
            do_op($sformatf("rnd%0d", i), ra, rb, rs, int'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)));
        end

        // Reset during the third RUN cycle
        @(negedge clk);
        in_a = 64'hFFFF_FFFF_FFFF_FFFF; in_b = 64'hFFFF_FFFF_FFFF_FFFF; in_add_n = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_out_sum", out_sum, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("after_rst", 64'd3, 64'd4, 1'b0, 0, 1'b0);
        chk("after_rst_sum7", out_sum, 64'd7);

        // Reset while holding a result in DONE
        @(negedge clk);
        in_a = 64'd9; in_b = 64'd1; in_add_n = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(lat);
        chk("donerst_pre_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("donerst_out_valid", 64'(out_valid), 64'd0);
        chk("donerst_out_cout", 64'(out_cout), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-word instance: one RUN cycle
        @(negedge clk);
        s_in_a = 16'hFFFF; s_in_b = 16'h0001; s_in_add_n = 1'b0; s_in_valid = 1'b1;
        chk("w1_in_ready", 64'(s_in_ready), 64'd1);
        @(negedge clk);
        s_in_valid = 1'b0;
        chk("w1_valid_early", 64'(s_out_valid), 64'd0);
        @(negedge clk);
        chk("w1_valid", 64'(s_out_valid), 64'd1);
        chk("w1_sum", 64'(s_out_sum), 64'd0);
        chk("w1_cout", 64'(s_out_cout), 64'd1);
        chk("w1_ovf", 64'(s_out_ovf), 64'd0);
        s_out_ready = 1'b1;
        @(negedge clk);
        s_out_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            ra = 64'($urandom_range(0, 16'hFFFF));
            rb = 64'($urandom_range(0, 16'hFFFF));
            rs = 1'($urandom_range(0, 1));
            model(ra, rb, rs, 16, es1, ec1, eo1);
            s_in_a = ra[15:0]; s_in_b = rb[15:0]; s_in_add_n = rs; s_in_valid = 1'b1;
            @(negedge clk);
            s_in_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("w1r%0d_valid", i), 64'(s_out_valid), 64'd1);
            chk($sformatf("w1r%0d_sum", i), 64'(s_out_sum), es1);
            chk($sformatf("w1r%0d_cout", i), 64'(s_out_cout), 64'(ec1));
            chk($sformatf("w1r%0d_ovf", i), 64'(s_out_ovf), 64'(eo1));
            s_out_ready = 1'b1;
            @(negedge clk);
            s_out_ready = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
